// File: rtl/tt_um_lnl_soc.sv
// 8-bit accumulator SoC: 16-byte unified memory, strobe-driven loader,
// two-phase fetch/execute CPU and a registered output port.
module tt_um_lnl_soc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {PH_FETCH, PH_EXEC, PH_HALT} phase_t;

  logic [7:0] r_mem [16];
  logic [3:0] r_pc;
  logic [3:0] r_lp;
  logic [7:0] r_a;
  logic [7:0] r_out;
  logic [7:0] r_ir;
  logic       r_c;
  logic       r_s;
  phase_t     r_phase;

  logic       w_load;
  logic       w_strobe;
  logic [3:0] w_opc;
  logic [3:0] w_n;
  logic [7:0] w_mem_n;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic       w_unused;

  assign w_load   = uio_in[7];
  assign w_strobe = uio_in[6];
  assign w_opc    = r_ir[7:4];
  assign w_n      = r_ir[3:0];
  assign w_mem_n  = r_mem[w_n];
  assign w_sum    = {1'b0, r_a} + {1'b0, w_mem_n};
  // Bit 8 of the 9-bit difference is set exactly when A < MEM[n] (borrow).
  assign w_diff   = {1'b0, r_a} - {1'b0, w_mem_n};
  assign w_unused = &{1'b0, uio_in[5:0]};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
      r_pc    <= 4'h0;
      r_lp    <= 4'h0;
      r_a     <= 8'h00;
      r_out   <= 8'h00;
      r_ir    <= 8'h00;
      r_c     <= 1'b0;
      r_s     <= 1'b0;
      r_phase <= PH_FETCH;
    end else if (ena) begin
      r_s <= w_strobe;
      if (w_load) begin
        r_pc    <= 4'h0;
        r_phase <= PH_FETCH;
        if (w_strobe && !r_s) begin
          r_mem[r_lp] <= ui_in;
          r_lp        <= r_lp + 4'd1;
        end
      end else begin
        r_lp <= 4'h0;
        case (r_phase)
          PH_FETCH: begin
            r_ir    <= r_mem[r_pc];
            r_pc    <= r_pc + 4'd1;
            r_phase <= PH_EXEC;
          end
          PH_EXEC: begin
            r_phase <= PH_FETCH;
            case (w_opc)
              4'h0: ;
              4'h1: r_a <= w_mem_n;
              4'h2: r_mem[w_n] <= r_a;
              4'h3: {r_c, r_a} <= w_sum;
              4'h4: {r_c, r_a} <= w_diff;
              4'h5: r_a <= r_a & w_mem_n;
              4'h6: r_a <= r_a | w_mem_n;
              4'h7: r_a <= r_a ^ w_mem_n;
              4'h8: r_a <= {4'h0, w_n};
              4'h9: r_pc <= w_n;
              4'hA: if (r_a == 8'h00) r_pc <= w_n;
              4'hB: if (r_c) r_pc <= w_n;
              4'hC: r_out <= r_a;
              4'hD: r_a <= ui_in;
              4'hE: r_a <= ~r_a;
              4'hF: r_phase <= PH_HALT;
              default: ;
            endcase
          end
          default: r_phase <= PH_HALT;
        endcase
      end
    end
  end

  assign uo_out  = r_out;
  assign uio_out = {2'b00, r_c, (r_phase == PH_HALT), r_pc};
  assign uio_oe  = 8'h3F;

endmodule

// File: tb/tb_tt_um_lnl_soc.sv
// Directed bench for tt_um_lnl_soc: loads small programs through the strobe
// loader, runs them and checks uo_out / uio_out against hand-computed values.
module tb_tt_um_lnl_soc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int passed = 0;
  logic [7:0] img [16];

  tt_um_lnl_soc dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    $display("check %-14s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic load_byte(input logic [7:0] b);
    ui_in  = b;
    uio_in = 8'hC0;
    tick();
    uio_in = 8'h80;
    tick();
  endtask

  task automatic load_img(input int n);
    uio_in = 8'h80;
    for (int i = 0; i < n; i++) load_byte(img[i]);
  endtask

  task automatic run(input int n);
    uio_in = 8'h00;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    tick(); tick();
    rst_n = 1'b0;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h3F);

    // NOP-filled memory: PC steps once per 2 cycles and wraps 15 -> 0
    run(1);
    check("nop_pc1", uio_out, 8'h01);
    run(30);
    check("nop_wrap", uio_out, 8'h00);
    run(2);
    check("nop_pc1b", uio_out, 8'h01);

    // LDI 5; ADD [15]=07; OUT; HLT
    img = '{8'h85, 8'h3F, 8'hC0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
    load_img(16);
    check("ld_pc0", uio_out, 8'h00);
    run(6);
    check("p1_out", uo_out, 8'h0C);
    run(1);
    check("p1_prehalt", uio_out, 8'h04);
    run(1);
    check("p1_halt", uio_out, 8'h14);
    run(4);
    check("p1_stay", uio_out, 8'h14);

    // Carry / JC: LDI 1; ADD FF -> 00,C=1; JC 5; ...; NOT; OUT; HLT
    img = '{8'h81, 8'h3F, 8'hB5, 8'hC0, 8'hF0, 8'hE0, 8'hC0, 8'hF0,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    load_img(16);
    check("ld_keep_out", uo_out, 8'h0C);
    check("ld_hold", uio_out, 8'h00);
    run(4);
    check("p2_carry", uio_out, 8'h22);
    run(2);
    check("p2_jc", uio_out, 8'h25);
    run(6);
    check("p2_out", uo_out, 8'hFF);
    check("p2_halt", uio_out, 8'h38);

    // SUB borrow / JZ
    img = '{8'h83, 8'h4E, 8'hA5, 8'hC0, 8'hF0, 8'hC0, 8'h83, 8'h4F,
            8'hC0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04};
    load_img(16);
    run(4);
    check("sub_eq_c0", uio_out, 8'h02);
    run(2);
    check("jz_taken", uio_out, 8'h05);
    run(2);
    check("sub_eq_a0", uo_out, 8'h00);
    run(4);
    check("sub_borrow", uio_out, 8'h28);
    run(2);
    check("sub_a_ff", uo_out, 8'hFF);
    run(2);
    check("p3_halt", uio_out, 8'h3A);

    // Echo loop: IN; OUT; JMP 0
    img[0] = 8'hD0; img[1] = 8'hC0; img[2] = 8'h90;
    load_img(3);
    uio_in = 8'h00;
    ui_in  = 8'h33;
    run(4);
    check("echo_33", uo_out, 8'h33);
    ui_in = 8'h5A;
    run(6);
    check("echo_5a", uo_out, 8'h5A);
    check("echo_pc", uio_out, 8'h22);
    ena = 1'b0;
    ui_in = 8'hA5;
    repeat (5) tick();
    check("frz_out", uo_out, 8'h5A);
    check("frz_pc", uio_out, 8'h22);
    ena = 1'b1;
    run(6);
    check("echo_a5", uo_out, 8'hA5);

    // Reset mid-run
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("rst_run_uo", uo_out, 8'h00);
    check("rst_run_uio", uio_out, 8'h00);

    // Reset mid-load, then a fresh session (first strobe rises while ena=0)
    img[0] = 8'hAA; img[1] = 8'hBB;
    load_img(2);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    ui_in = 8'h8F; ena = 1'b0; uio_in = 8'hC0;
    tick();
    ena = 1'b1;
    tick();
    uio_in = 8'h80;
    tick();
    load_byte(8'h3E);
    load_byte(8'hC0);
    load_byte(8'hF0);
    run(8);
    check("relo_out", uo_out, 8'h0F);
    check("relo_halt", uio_out, 8'h14);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
